preload_fifo_ctrl: RTL and testbench
====================================

Name: preload_fifo_ctrl

Overview:
- Sequences one tile of ifmap vectors through the AXIS preload FIFO.
- Gates AXI-Stream beats into the FIFO as write strobes and counts beats into rows (MAC vectors).
- Issues FIFO pops when the MAC array is ready, then issues the FIFO clear pulse and reports completion.
- Sits between the AXIS slave, the preload FIFO and the layer scheduler.

Parameters:
- AXIS_PRELOAD_FIFO_DEPTH, 4, depth of the controlled FIFO; sets the fifo_cnt width.
- ROW_W, 16, width of the row counters and row_total.
- CH_W, 12, width of input_channel_size.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle tile start; honoured only in IDLE
- abort  in  1  synchronous abort, any state
- input_channel_size  in  CH_W  channels per vector; latched at start
- row_total  in  ROW_W  vectors in the tile; latched at start
- s_axis_tvalid  in  1  upstream beat valid
- s_axis_tlast  in  1  upstream last beat
- s_axis_tready  out  1  beat accept
- load_axis_preload  out  1  FIFO write strobe
- fifo_full  in  1  FIFO full
- fifo_empty  in  1  FIFO empty
- fifo_read  out  1  FIFO pop
- mac_ready  in  1  MAC array consumes the head vector this cycle
- axis_clear  out  1  FIFO clear pulse
- busy  out  1  high outside IDLE
- done  out  1  single-cycle tile complete
- err_tlast  out  1  sticky tlast mismatch

Behaviour:
- Reset values: all outputs, counters, latched registers and err_tlast are 0; state is IDLE.
- States and transitions:
  - IDLE: on start, latch the inputs and clear the counters and err_tlast. If the latched row_total is 0, go to CLEAR; otherwise go to LOAD.
  - LOAD: accepts beats and pops rows. When the final beat of row row_total-1 is accepted, go to DRAIN.
  - DRAIN: pops only. When rows_read equals row_total, go to CLEAR.
  - CLEAR: axis_clear=1 for exactly one cycle, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Derived values: words_per_row = floor(input_channel_size/6)+1. This matches the FIFO row-commit rule (6 channels per 32-bit beat).
- Combinational handshake:
  - s_axis_tready = (state==LOAD) & (~fifo_full | fifo_read).
  - load_axis_preload = s_axis_tvalid & s_axis_tready.
- Pop rule: fifo_read = (state==LOAD|DRAIN) & ~fifo_empty & mac_ready & (rows_read < row_total).
- Beat counting:
  - word_cnt increments per accepted beat.
  - On the beat where word_cnt == words_per_row-1, word_cnt wraps to 0 and rows_written increments.
- Pop counting: rows_read increments on each fifo_read.
- Simultaneous push and pop in the same cycle are legal, including when fifo_full=1, since the pop frees the slot.
- Latency: no added latency from tvalid to write strobe, or from mac_ready to pop. The tile ends with the last pop, then 1 cycle of CLEAR and 1 cycle of DONE.
- tlast checking:
  - tlast on an accepted beat that is not the final beat of the tile sets err_tlast.
  - A missing tlast on the final beat also sets err_tlast.
  - The beat is still written in both cases.
  - err_tlast holds until the next honoured start.
- start while busy=1 is ignored.
- abort outside IDLE: the next state is CLEAR, then DONE. Counters hold until the next start. abort in IDLE is ignored.
- Counters use ROW_W bits; row_total is at most 2^ROW_W-1, so there is no wrap.
- Reset mid-tile returns to IDLE immediately. axis_clear is not issued; the FIFO is cleared by its own reset.

Optional Feature:
- Macro: PRELOAD_CTRL_PERF_EN.
- When defined, the block adds two outputs:
  - starve_cycles[31:0]: counts cycles with busy & mac_ready & fifo_empty & (rows_read<row_total).
  - backpressure_cycles[31:0]: counts cycles with s_axis_tvalid & ~s_axis_tready while in LOAD.
  - Both counters clear on an honoured start, saturate at all-ones, and reset to 0.
- When undefined, neither port nor logic exists and behaviour is otherwise identical.

Test Plan:
- Basic tile: input_channel_size=12, row_total=2, tvalid always 1, mac_ready always 1, tlast on beat 6 -> 6 beats accepted, 2 pops, axis_clear 1 cycle, done 1 cycle, err_tlast=0.
- Backpressure: input_channel_size=0 (1 beat/row), row_total=6, mac_ready=0 until 6 beats offered, FIFO depth 4 -> s_axis_tready low once fifo_full. Raising mac_ready accepts a beat in the same cycle as a pop; total pops = 6.
- tlast errors:
  - tlast asserted on beat 3 of 6 -> err_tlast=1 after that beat; tile still completes.
  - No tlast on the final beat -> err_tlast=1.
- Edge cases:
  - row_total=0 with start -> CLEAR then DONE within 2 cycles; no tready.
  - start during LOAD -> ignored.
- Abort and reset:
  - abort during LOAD after 2 beats -> axis_clear next cycle, then done.
  - rst_n low mid-DRAIN -> all outputs 0 asynchronously; state returns to IDLE.
- PRELOAD_CTRL_PERF_EN build: mac_ready=1, tvalid gapped 3 cycles per beat, input_channel_size=0, row_total=2 -> starve_cycles is nonzero, backpressure_cycles=0.

Source files
------------

// File: rtl/preload_fifo_ctrl.sv
// Tile sequencer for the AXIS preload FIFO: gates beats in, pops rows to the MAC array,
// then clears the FIFO. Define PRELOAD_CTRL_PERF_EN to add starvation/backpressure counters.
module preload_fifo_ctrl #(
  parameter int AXIS_PRELOAD_FIFO_DEPTH = 4,
  parameter int ROW_W                   = 16,
  parameter int CH_W                    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CH_W-1:0]  input_channel_size,
  input  logic [ROW_W-1:0] row_total,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic             load_axis_preload,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             fifo_read,
  input  logic             mac_ready,
  output logic             axis_clear,
  output logic             busy,
  output logic             done,
  output logic             err_tlast
`ifdef PRELOAD_CTRL_PERF_EN
  ,
  output logic [31:0]      starve_cycles,
  output logic [31:0]      backpressure_cycles
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_CLEAR, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [ROW_W-1:0] row_total_q, rows_written, rows_read, rows_read_nxt;
  logic [CH_W-1:0]  wpr_q, word_cnt;
  logic             start_ok, in_load, in_pop, row_end, tile_end, rows_left;

  assign start_ok      = (state == S_IDLE) & start;
  assign in_load       = (state == S_LOAD);
  assign in_pop        = in_load | (state == S_DRAIN);
  assign rows_left     = (rows_read < row_total_q);
  assign fifo_read     = in_pop & ~fifo_empty & mac_ready & rows_left;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a beat.
  assign s_axis_tready = in_load & (~fifo_full | fifo_read);
  assign load_axis_preload = s_axis_tvalid & s_axis_tready;

  assign row_end       = (word_cnt == wpr_q - CH_W'(1));
  assign tile_end      = row_end & (rows_written == row_total_q - ROW_W'(1));
  assign rows_read_nxt = rows_read + ROW_W'(fifo_read);

  assign busy       = (state != S_IDLE);
  assign axis_clear = (state == S_CLEAR);
  assign done       = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (row_total == '0) ? S_CLEAR : S_LOAD;
      S_LOAD:  if (load_axis_preload & tile_end) state_nxt = S_DRAIN;
      S_DRAIN: if (rows_read_nxt == row_total_q) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nxt = S_CLEAR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_total_q  <= '0;
      wpr_q        <= '0;
      word_cnt     <= '0;
      rows_written <= '0;
      rows_read    <= '0;
      err_tlast    <= 1'b0;
    end else if (start_ok) begin
      row_total_q  <= row_total;
      // One 32-bit beat carries 6 channels; the FIFO commits a row on this count.
      wpr_q        <= input_channel_size / CH_W'(6) + CH_W'(1);
      word_cnt     <= '0;
      rows_written <= '0;
      rows_read    <= '0;
      err_tlast    <= 1'b0;
    end else begin
      if (load_axis_preload) begin
        word_cnt <= row_end ? '0 : word_cnt + CH_W'(1);
        if (row_end) rows_written <= rows_written + ROW_W'(1);
        if (s_axis_tlast != tile_end) err_tlast <= 1'b1;
      end
      rows_read <= rows_read_nxt;
    end
  end

`ifdef PRELOAD_CTRL_PERF_EN
  logic starve_hit, bp_hit;
  assign starve_hit = busy & mac_ready & fifo_empty & rows_left;
  assign bp_hit     = s_axis_tvalid & ~s_axis_tready & in_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cycles       <= '0;
      backpressure_cycles <= '0;
    end else if (start_ok) begin
      starve_cycles       <= '0;
      backpressure_cycles <= '0;
    end else begin
      if (starve_hit && (starve_cycles != '1)) starve_cycles <= starve_cycles + 32'd1;
      if (bp_hit && (backpressure_cycles != '1)) backpressure_cycles <= backpressure_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_preload_fifo_ctrl.sv
// Randomized bench for preload_fifo_ctrl: a beat/row-level FIFO environment plus a
// tile-progress reference model checked against the DUT every cycle.
module tb_preload_fifo_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 0, abort = 0, s_axis_tvalid = 0, s_axis_tlast = 0;
  logic [11:0] input_channel_size = '0;
  logic [15:0] row_total = '0;
  logic        s_axis_tready, load_axis_preload, fifo_read, axis_clear, busy, done, err_tlast;
  logic        fifo_full = 0, fifo_empty = 1, mac_ready = 0;
`ifdef PRELOAD_CTRL_PERF_EN
  logic [31:0] starve_cycles, backpressure_cycles;
`endif

  preload_fifo_ctrl #(.AXIS_PRELOAD_FIFO_DEPTH(DEPTH), .ROW_W(16), .CH_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .input_channel_size(input_channel_size), .row_total(row_total),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .load_axis_preload(load_axis_preload), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_read(fifo_read), .mac_ready(mac_ready), .axis_clear(axis_clear), .busy(busy),
    .done(done), .err_tlast(err_tlast)
`ifdef PRELOAD_CTRL_PERF_EN
    , .starve_cycles(starve_cycles), .backpressure_cycles(backpressure_cycles)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  // reference model: 0 idle, 1 active (loading/draining), 2 clear, 3 done
  int m_mode = 0, m_rt = 0, m_wpr = 1, m_total = 0, m_beats = 0, m_rd = 0, m_err = 0;
  longint m_starve = 0, m_bp = 0;
  int fq_rows = 0, fq_part = 0;
  int pv = 100, pm = 100, bad_idx = -1, drop_last = 0, pa = 0, ps = 0, gap = 0, gap_cnt = 0;
  int req_start = 0, req_abort = 0;
  int n_load, n_pop, n_clr, n_done, n_rdy, n_both, n_cyc;
  logic d_clr, d_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    bit act, e_pop, e_rdy, e_load, d_pop, d_push;
    @(negedge clk);
    start = (req_start != 0) || (m_mode != 0 && $urandom_range(0, 999) < ps);
    abort = (req_abort != 0) || (m_mode != 0 && $urandom_range(0, 999) < pa);
    if (gap > 0) begin
      s_axis_tvalid = (gap_cnt == 0);
      gap_cnt = (gap_cnt == gap) ? 0 : gap_cnt + 1;
    end else s_axis_tvalid = ($urandom_range(0, 99) < pv);
    mac_ready    = ($urandom_range(0, 99) < pm);
    s_axis_tlast = (m_beats == m_total - 1);
    if (bad_idx == m_beats) s_axis_tlast = 1'b1;
    if (drop_last != 0 && m_beats == m_total - 1) s_axis_tlast = 1'b0;
    fifo_full  = (fq_rows >= DEPTH);
    fifo_empty = (fq_rows == 0);
    #1;
    act    = (m_mode == 1);
    e_pop  = act && !fifo_empty && mac_ready && (m_rd < m_rt);
    e_rdy  = act && (m_beats < m_total) && (!fifo_full || e_pop);
    e_load = s_axis_tvalid && e_rdy;
    chk("fifo_read", fifo_read, e_pop);
    chk("tready", s_axis_tready, e_rdy);
    chk("load", load_axis_preload, e_load);
    chk("busy", busy, m_mode != 0);
    chk("axis_clear", axis_clear, m_mode == 2);
    chk("done", done, m_mode == 3);
    chk("err_tlast", err_tlast, m_err);
`ifdef PRELOAD_CTRL_PERF_EN
    chk("starve_cycles", starve_cycles, m_starve[31:0]);
    chk("bp_cycles", backpressure_cycles, m_bp[31:0]);
`endif
    d_pop = fifo_read; d_push = load_axis_preload; d_clr = axis_clear; d_done = done;
    n_cyc++;
    if (d_push) n_load++;
    if (d_pop) n_pop++;
    if (d_clr) n_clr++;
    if (d_done) n_done++;
    if (s_axis_tready) n_rdy++;
    if (d_push && d_pop) n_both++;
    @(posedge clk);
    // FIFO environment reacts to the DUT's strobes
    if (d_clr) begin fq_rows = 0; fq_part = 0; end
    else begin
      if (d_pop && fq_rows > 0) fq_rows--;
      if (d_push) begin
        fq_part++;
        if (fq_part >= m_wpr) begin fq_part = 0; fq_rows++; end
      end
    end
    if (m_mode == 0) begin
      if (start) begin
        m_rt = row_total; m_wpr = input_channel_size / 6 + 1; m_total = m_rt * m_wpr;
        m_beats = 0; m_rd = 0; m_err = 0; m_starve = 0; m_bp = 0;
        m_mode = (m_rt == 0) ? 2 : 1;
      end
    end else begin
      if (mac_ready && fifo_empty && m_rd < m_rt && m_starve < 64'hFFFF_FFFF) m_starve++;
      if (act && m_beats < m_total && s_axis_tvalid && !e_rdy && m_bp < 64'hFFFF_FFFF) m_bp++;
      if (e_load) begin
        if (s_axis_tlast != (m_beats == m_total - 1)) m_err = 1;
        m_beats++;
      end
      if (e_pop) m_rd++;
      if (abort) m_mode = 2;
      else if (m_mode == 1) begin
        if (m_beats == m_total && m_rd == m_rt) m_mode = 2;
      end else if (m_mode == 2) m_mode = 3;
      else m_mode = 0;
    end
  endtask

  task automatic start_tile(input int ch, input int rt);
    input_channel_size = 12'(ch);
    row_total = 16'(rt);
    n_load = 0; n_pop = 0; n_clr = 0; n_done = 0; n_rdy = 0; n_both = 0; n_cyc = 0;
    req_start = 1; cycle(); req_start = 0;
    n_cyc = 0;
  endtask

  task automatic reset_model();
    m_mode = 0; m_rt = 0; m_wpr = 1; m_total = 0; m_beats = 0; m_rd = 0; m_err = 0;
    m_starve = 0; m_bp = 0; fq_rows = 0; fq_part = 0;
  endtask

  // asynchronous reset between edges; outputs must drop without a clock
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_clear", axis_clear, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_tlast, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_read", fifo_read, 0);
    reset_model();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic finish_tile(input int budget);
    int n = 0;
    while (m_mode != 0 && n < budget) begin cycle(); n++; end
    if (m_mode != 0) begin
      vectors++; miscompares++;
      $display("FAIL timeout: tile still active after %0d cycles", budget);
      do_reset();
    end
  endtask

  initial begin
    #3;
    chk("init_busy", busy, 0);
    chk("init_err", err_tlast, 0);
    chk("init_tready", s_axis_tready, 0);
    @(negedge clk); rst_n = 1'b1;

    // basic tile: 12 channels -> 3 beats/row, 2 rows
    pv = 100; pm = 100;
    start_tile(12, 2); finish_tile(100);
    chk("basic_loads", n_load, 6);
    chk("basic_pops", n_pop, 2);
    chk("basic_clear", n_clr, 1);
    chk("basic_done", n_done, 1);
    chk("basic_err", err_tlast, 0);

    // backpressure: FIFO fills at 4 rows while the MAC stalls
    pm = 0;
    start_tile(0, 6);
    repeat (8) cycle();
    chk("bp_loads_at_full", n_load, 4);
    pm = 100; finish_tile(100);
    chk("bp_loads", n_load, 6);
    chk("bp_pops", n_pop, 6);
    chk("bp_push_pop_same", n_both > 0, 1);

    // early tlast on beat 3 of 6, then missing tlast on the final beat
    bad_idx = 2;
    start_tile(12, 2); finish_tile(100);
    chk("early_tlast_err", err_tlast, 1);
    chk("early_tlast_pops", n_pop, 2);
    bad_idx = -1; drop_last = 1;
    start_tile(12, 2); finish_tile(100);
    chk("missing_tlast_err", err_tlast, 1);
    drop_last = 0;

    // zero-row tile
    start_tile(12, 0); finish_tile(10);
    chk("zero_cycles", n_cyc, 2);
    chk("zero_clear", n_clr, 1);
    chk("zero_done", n_done, 1);
    chk("zero_tready", n_rdy, 0);
    chk("zero_err_cleared", err_tlast, 0);

    // start during LOAD is ignored
    pv = 50;
    start_tile(12, 3);
    repeat (3) cycle();
    req_start = 1; cycle(); req_start = 0;
    finish_tile(200);
    chk("restart_loads", n_load, 9);
    chk("restart_pops", n_pop, 3);

    // abort after 2 beats
    pv = 100;
    start_tile(12, 2);
    for (int i = 0; i < 20 && n_load < 2; i++) cycle();
    req_abort = 1; cycle(); req_abort = 0;
    cycle(); chk("abort_clear", d_clr, 1);
    cycle(); chk("abort_done", d_done, 1);
    finish_tile(10);

    // reset while draining
    pm = 0;
    start_tile(12, 3);
    for (int i = 0; i < 40 && m_beats < m_total; i++) cycle();
    cycle();
    chk("drain_busy", busy, 1);
    do_reset();
    pm = 100;

`ifdef PRELOAD_CTRL_PERF_EN
    gap = 3;
    start_tile(0, 2); finish_tile(100);
    chk("perf_starve_nz", starve_cycles != 0, 1);
    chk("perf_bp_zero", backpressure_cycles, 0);
    gap = 0;
`endif

    // randomized tiles with stray starts, aborts and tlast faults
    pa = 10; ps = 20;
    for (int t = 0; t < 40; t++) begin
      pv = $urandom_range(20, 100); pm = $urandom_range(20, 100);
      bad_idx = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 10) : -1;
      drop_last = ($urandom_range(0, 9) == 0);
      start_tile($urandom_range(0, 30), $urandom_range(0, 5));
      finish_tile(2000);
      repeat ($urandom_range(0, 2)) cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
